hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, the register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, the stall-counter width.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports ID_Rs and ID_Rt, input, REG_ADDR_W each, the source registers of the instruction in ID.
REQ-006 SHALL have port ID_Rd, input, REG_ADDR_W, the destination of the instruction in ID.
REQ-007 SHALL have ports ID_RegWrite, ID_MemRead and ID_Valid, input, 1 each, the decoded ID controls.
REQ-008 SHALL have port EX_BranchTaken, input, 1, the branch resolved taken in EX.
REQ-009 SHALL have ports Fwd_A_SEL and Fwd_B_SEL, output, 2 each, the select drives of the EX operand 3:1 muxes.
REQ-010 SHALL have ports Stall_IF_ID, Flush_IF_ID and Bubble_ID_EX, output, 1 each.
REQ-011 SHALL have port Stall_Count, output, CNT_W, the number of load-use stall cycles.

Function
REQ-012 SHALL hold three internal tracking stages, EX, MEM and WB; each stage holds {Rs, Rt, Rd, RegWrite, MemRead, Valid}; MEM and WB use only Rd, RegWrite and Valid.
REQ-013 SHALL advance the stages every cycle: WB<=MEM, MEM<=EX, EX<=ID fields; when Bubble_ID_EX=1, EX SHALL instead load a bubble (all fields 0).
REQ-014 SHALL define a stage as a write hazard only when Valid=1, RegWrite=1 and Rd!=0.
REQ-015 SHALL drive Fwd_A_SEL combinationally from the registered stage state: 1 if the MEM stage is a write hazard with MEM.Rd==EX.Rs; else 2 if WB is a write hazard with WB.Rd==EX.Rs; else 0.
REQ-016 SHALL drive Fwd_B_SEL with the same rule as REQ-015, using EX.Rt.
REQ-017 SHALL never drive value 3 on either select; register 0 SHALL never be forwarded.
REQ-018 SHALL define load-use as: EX.Valid=1 & EX.MemRead=1 & EX.Rd!=0 & ID_Valid=1 & (EX.Rd==ID_Rs | EX.Rd==ID_Rt).
REQ-019 SHALL on load-use assert Stall_IF_ID=1 and Bubble_ID_EX=1 in the same cycle, combinationally; the stall SHALL last exactly one cycle, because the load leaves EX on the next edge.
REQ-020 SHALL on EX_BranchTaken=1 assert Flush_IF_ID=1 and Bubble_ID_EX=1, and force Stall_IF_ID=0.
REQ-021 SHALL give flush priority over load-use when both occur in the same cycle, and SHALL NOT increment Stall_Count in that cycle.
REQ-022 SHALL increment Stall_Count at the edge ending each cycle with Stall_IF_ID=1, saturating at all-ones without wrap.
REQ-023 SHALL add zero latency from ID inputs to Stall_IF_ID, Flush_IF_ID and Bubble_ID_EX, and one cycle from ID inputs to the forwarding selects.

Reset
REQ-024 SHALL on RESET=1 immediately clear all tracking stages to bubbles and Stall_Count to 0, independent of CLK.
REQ-025 SHALL therefore drive Fwd_A_SEL=Fwd_B_SEL=0 and Stall_IF_ID=Flush_IF_ID=0 while RESET is asserted; Bubble_ID_EX SHALL reflect only EX_BranchTaken.
REQ-026 SHALL discard in-flight instructions when reset is asserted mid-operation; after deassertion the first valid ID instruction SHALL see no hazards.

Structure
REQ-027 SHALL place the select encodings (FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2) and the bubble constant in the shared CPU package.
REQ-028 SHALL implement each tracking stage as one sub-module, hazard_track_reg: a register with async reset and a synchronous bubble input, instantiated three times.

Verification
REQ-029 SHALL cover MEM-stage forwarding: ADD r3 followed by SUB r4,r3,r5 -> Fwd_A_SEL=1 and Fwd_B_SEL=0 in the SUB EX cycle.
REQ-030 SHALL cover WB-stage forwarding: ADD r3, NOP, then OR r6,r7,r3 -> Fwd_B_SEL=2 in the OR EX cycle.
REQ-031 SHALL cover the double hazard: ADD r3, ADD r3, then AND r8,r3,r3 -> Fwd_A_SEL=Fwd_B_SEL=1, with the newest producer winning.
REQ-032 SHALL cover load-use: LW r2, then ADD r9,r2,r1 -> exactly one cycle of Stall_IF_ID=1 and Bubble_ID_EX=1, then Fwd_A_SEL=2 and Stall_Count=1.
REQ-033 SHALL cover flush versus load-use: load-use plus EX_BranchTaken in the same cycle -> Flush_IF_ID=1, Stall_IF_ID=0, Stall_Count unchanged.
REQ-034 SHALL cover mid-operation reset: RESET pulsed while an LW is in EX -> stages cleared, selects 0, no stall afterwards; also a writer with Rd=0 followed by a reader of r0 -> selects 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// hazard_ctrl_pkg : shared forwarding encodings and tracking-stage types
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  // Select encodings for the EX operand 3:1 muxes
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic valid;
  } trk_ctrl_t;

  localparam trk_ctrl_t TRK_CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0, valid: 1'b0};

  function automatic logic is_write_hazard(input trk_ctrl_t ctrl, input logic rd_nonzero);
    return ctrl.valid & ctrl.reg_write & rd_nonzero;
  endfunction

  // The newer producer (MEM) must win over the older one (WB)
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_EXMEM;
    end else if (wb_hit) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_track_reg.sv
// ============================================================================
// hazard_track_reg : one pipeline tracking stage with async reset and sync bubble
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_track_reg
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  bubble,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  trk_ctrl_t             ctrl_in,
  output logic [REG_ADDR_W-1:0] rs_q,
  output logic [REG_ADDR_W-1:0] rt_q,
  output logic [REG_ADDR_W-1:0] rd_q,
  output trk_ctrl_t             ctrl_q
);

  logic [REG_ADDR_W-1:0] rs_d;
  logic [REG_ADDR_W-1:0] rt_d;
  logic [REG_ADDR_W-1:0] rd_d;
  trk_ctrl_t             ctrl_d;

  always_comb begin
    rs_d   = rs_in;
    rt_d   = rt_in;
    rd_d   = rd_in;
    ctrl_d = ctrl_in;
    if (bubble) begin
      rs_d   = '0;
      rt_d   = '0;
      rd_d   = '0;
      ctrl_d = TRK_CTRL_BUBBLE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= TRK_CTRL_BUBBLE;
    end else begin
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : operand forwarding selects, load-use stall and branch flush
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic [REG_ADDR_W-1:0] ID_Rd,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_Valid,
  input  logic                  EX_BranchTaken,
  output logic [1:0]            Fwd_A_SEL,
  output logic [1:0]            Fwd_B_SEL,
  output logic                  Stall_IF_ID,
  output logic                  Flush_IF_ID,
  output logic                  Bubble_ID_EX,
  output logic [CNT_W-1:0]      Stall_Count
);

  trk_ctrl_t             id_ctrl;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
  logic [REG_ADDR_W-1:0] mem_rs, mem_rt, mem_rd;
  logic [REG_ADDR_W-1:0] wb_rs, wb_rt, wb_rd;
  trk_ctrl_t             ex_ctrl, mem_ctrl, wb_ctrl;

  logic                  mem_wr_hz;
  logic                  wb_wr_hz;
  logic                  load_use;
  logic [CNT_W-1:0]      stall_count_d;
  logic [CNT_W-1:0]      stall_count_q;
  logic                  unused_wb_fields;

  assign id_ctrl = '{reg_write: ID_RegWrite, mem_read: ID_MemRead, valid: ID_Valid};

  hazard_track_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex_stage (
    .CLK     (CLK),
    .RESET   (RESET),
    .bubble  (Bubble_ID_EX),
    .rs_in   (ID_Rs),
    .rt_in   (ID_Rt),
    .rd_in   (ID_Rd),
    .ctrl_in (id_ctrl),
    .rs_q    (ex_rs),
    .rt_q    (ex_rt),
    .rd_q    (ex_rd),
    .ctrl_q  (ex_ctrl)
  );

  hazard_track_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem_stage (
    .CLK     (CLK),
    .RESET   (RESET),
    .bubble  (1'b0),
    .rs_in   (ex_rs),
    .rt_in   (ex_rt),
    .rd_in   (ex_rd),
    .ctrl_in (ex_ctrl),
    .rs_q    (mem_rs),
    .rt_q    (mem_rt),
    .rd_q    (mem_rd),
    .ctrl_q  (mem_ctrl)
  );

  hazard_track_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb_stage (
    .CLK     (CLK),
    .RESET   (RESET),
    .bubble  (1'b0),
    .rs_in   (mem_rs),
    .rt_in   (mem_rt),
    .rd_in   (mem_rd),
    .ctrl_in (mem_ctrl),
    .rs_q    (wb_rs),
    .rt_q    (wb_rt),
    .rd_q    (wb_rd),
    .ctrl_q  (wb_ctrl)
  );

  // The retiring stage only needs its destination; its sources are dropped here
  assign unused_wb_fields = ^{wb_rs, wb_rt, wb_ctrl.mem_read};

  always_comb begin
    mem_wr_hz = is_write_hazard(mem_ctrl, |mem_rd);
    wb_wr_hz  = is_write_hazard(wb_ctrl, |wb_rd);
    Fwd_A_SEL = fwd_select(mem_wr_hz && (mem_rd == ex_rs), wb_wr_hz && (wb_rd == ex_rs));
    Fwd_B_SEL = fwd_select(mem_wr_hz && (mem_rd == ex_rt), wb_wr_hz && (wb_rd == ex_rt));
  end

  always_comb begin
    load_use = ex_ctrl.valid && ex_ctrl.mem_read && (ex_rd != '0) && ID_Valid &&
               ((ex_rd == ID_Rs) || (ex_rd == ID_Rt));
    // A taken branch squashes the ID instruction, so a pending stall is moot
    Stall_IF_ID  = load_use && !EX_BranchTaken;
    Flush_IF_ID  = EX_BranchTaken && !RESET;
    Bubble_ID_EX = load_use || EX_BranchTaken;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (Stall_IF_ID && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign Stall_Count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed and randomized checks against a history-queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_rw, id_mr, id_v, br;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, flush, bubble;
  logic [CW-1:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ID_Rs          (id_rs),
    .ID_Rt          (id_rt),
    .ID_Rd          (id_rd),
    .ID_RegWrite    (id_rw),
    .ID_MemRead     (id_mr),
    .ID_Valid       (id_v),
    .EX_BranchTaken (br),
    .Fwd_A_SEL      (fwd_a),
    .Fwd_B_SEL      (fwd_b),
    .Stall_IF_ID    (stall),
    .Flush_IF_ID    (flush),
    .Bubble_ID_EX   (bubble),
    .Stall_Count    (cnt)
  );

  always #5 CLK = ~CLK;

  // hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB
  typedef struct {
    int rs;
    int rt;
    int rd;
    bit rw;
    bit mr;
    bit v;
  } instr_t;

  instr_t hist[$];
  int     m_cnt;

  function automatic instr_t nop_instr();
    instr_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(nop_instr());
    m_cnt = 0;
  endfunction

  // Age 1 (MEM) is checked before age 2 (WB); the age doubles as the select code
  function automatic int m_fwd(int src);
    instr_t p;
    for (int age = 1; age <= 2; age++) begin
      p = hist[age];
      if (p.v && p.rw && p.rd != 0 && p.rd == src) return age;
    end
    return 0;
  endfunction

  function automatic bit m_load_use();
    instr_t e;
    e = hist[0];
    return e.v && e.mr && e.rd != 0 && id_v &&
           (e.rd == int'(id_rs) || e.rd == int'(id_rt));
  endfunction

  function automatic bit m_stall();
    return m_load_use() && !br;
  endfunction

  function automatic bit m_flush();
    return br && !RESET;
  endfunction

  function automatic bit m_bubble();
    return m_load_use() || br;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, ":fwd_a"},  32'(fwd_a),  32'(m_fwd(hist[0].rs)));
    check({tag, ":fwd_b"},  32'(fwd_b),  32'(m_fwd(hist[0].rt)));
    check({tag, ":stall"},  32'(stall),  32'(m_stall()));
    check({tag, ":flush"},  32'(flush),  32'(m_flush()));
    check({tag, ":bubble"}, 32'(bubble), 32'(m_bubble()));
    check({tag, ":count"},  32'(cnt),    32'(m_cnt));
  endtask

  task automatic drive(input string tag, input int rs, input int rt, input int rd,
                       input bit rw, input bit mr, input bit v, input bit b);
    id_rs = AW'(rs);
    id_rt = AW'(rt);
    id_rd = AW'(rd);
    id_rw = rw;
    id_mr = mr;
    id_v  = v;
    br    = b;
    #3;
    check_model(tag);
  endtask

  task automatic advance();
    bit     s;
    bit     bub;
    instr_t nx;
    s   = m_stall();
    bub = m_bubble();
    nx  = '{rs: int'(id_rs), rt: int'(id_rt), rd: int'(id_rd), rw: id_rw, mr: id_mr, v: id_v};
    if (bub) nx = nop_instr();
    @(posedge CLK);
    #1;
    if (RESET) begin
      model_reset();
    end else begin
      hist.push_front(nx);
      void'(hist.pop_back());
      if (s && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  initial begin
    RESET = 1'b1;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_rw = 1'b0; id_mr = 1'b0; id_v = 1'b0; br = 1'b0;
    model_reset();

    // Reset state, including branch during reset
    #2;
    check_model("reset");
    br = 1'b1;
    #1;
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_bubble", 32'(bubble), 32'd1);
    br = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // MEM-stage forwarding: ADD r3 ; SUB r4,r3,r5
    drive("add_r3", 1, 2, 3, 1, 0, 1, 0); advance();
    drive("sub_r4", 3, 5, 4, 1, 0, 1, 0); advance();
    drive("nop_a", 0, 0, 0, 0, 0, 0, 0);
    check("mem_fwd_a", 32'(fwd_a), 32'd1);
    check("mem_fwd_b", 32'(fwd_b), 32'd0);
    advance();

    // WB-stage forwarding: ADD r3 ; NOP ; OR r6,r7,r3
    drive("add_r3b", 1, 2, 3, 1, 0, 1, 0); advance();
    drive("nop_b", 0, 0, 0, 0, 0, 0, 0); advance();
    drive("or_r6", 7, 3, 6, 1, 0, 1, 0); advance();
    drive("nop_c", 0, 0, 0, 0, 0, 0, 0);
    check("wb_fwd_b", 32'(fwd_b), 32'd2);
    check("wb_fwd_a", 32'(fwd_a), 32'd0);
    advance();

    // Double hazard: newest producer wins
    drive("add_r3c", 1, 2, 3, 1, 0, 1, 0); advance();
    drive("add_r3d", 4, 5, 3, 1, 0, 1, 0); advance();
    drive("and_r8", 3, 3, 8, 1, 0, 1, 0); advance();
    drive("nop_d", 0, 0, 0, 0, 0, 0, 0);
    check("dbl_fwd_a", 32'(fwd_a), 32'd1);
    check("dbl_fwd_b", 32'(fwd_b), 32'd1);
    advance();

    // Load-use: LW r2 ; ADD r9,r2,r1
    drive("lw_r2", 1, 0, 2, 1, 1, 1, 0); advance();
    drive("lu_add", 2, 1, 9, 1, 0, 1, 0);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_bubble", 32'(bubble), 32'd1);
    advance();
    drive("lu_add_held", 2, 1, 9, 1, 0, 1, 0);
    check("lu_one_cycle", 32'(stall), 32'd0);
    check("lu_count", 32'(cnt), 32'd1);
    advance();
    drive("nop_e", 0, 0, 0, 0, 0, 0, 0);
    check("lu_fwd_a", 32'(fwd_a), 32'd2);
    advance();

    // Flush beats load-use in the same cycle
    drive("lw_r2b", 1, 0, 2, 1, 1, 1, 0); advance();
    drive("lu_br", 2, 1, 9, 1, 0, 1, 1);
    check("fl_flush", 32'(flush), 32'd1);
    check("fl_stall", 32'(stall), 32'd0);
    check("fl_bubble", 32'(bubble), 32'd1);
    advance();
    drive("nop_f", 0, 0, 0, 0, 0, 0, 0);
    check("fl_count", 32'(cnt), 32'd1);
    advance();

    // Mid-operation reset with LW in EX
    drive("lw_r2c", 1, 0, 2, 1, 1, 1, 0); advance();
    drive("pre_rst", 2, 1, 9, 1, 0, 1, 0);
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_b), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    br = 1'b1;
    #1;
    check("rst_br_flush", 32'(flush), 32'd0);
    check("rst_br_bubble", 32'(bubble), 32'd1);
    br = 1'b0;
    #1;
    check("rst_nobr_bubble", 32'(bubble), 32'd0);
    advance();
    RESET = 1'b0;
    drive("post_rst", 2, 1, 9, 1, 0, 1, 0);
    check("post_rst_stall", 32'(stall), 32'd0);
    advance();
    drive("nop_g", 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_fwd_a", 32'(fwd_a), 32'd0);
    advance();

    // Register 0 is never forwarded nor a load-use source
    drive("wr_r0", 1, 2, 0, 1, 0, 1, 0); advance();
    drive("rd_r0", 0, 0, 5, 1, 0, 1, 0); advance();
    drive("nop_h", 0, 0, 0, 0, 0, 0, 0);
    check("r0_fwd_a", 32'(fwd_a), 32'd0);
    check("r0_fwd_b", 32'(fwd_b), 32'd0);
    advance();
    drive("lw_r0", 1, 0, 0, 1, 1, 1, 0); advance();
    drive("rd_r0b", 0, 0, 6, 1, 0, 1, 0);
    check("r0_no_stall", 32'(stall), 32'd0);
    advance();

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      bit mr;
      mr = ($urandom_range(0, 2) == 0);
      drive("rnd",
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            mr ? 1'b1 : ($urandom_range(0, 3) != 0), mr,
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 99) == 0) begin
        #1;
        RESET = 1'b1;
        model_reset();
        #1;
        check_model("rnd_rst");
        advance();
        RESET = 1'b0;
      end else begin
        advance();
      end
    end

    // Counter saturation without wrap
    for (int n = 0; n < 20; n++) begin
      drive("sat_lw", 1, 0, 2, 1, 1, 1, 0); advance();
      drive("sat_use", 2, 2, 7, 1, 0, 1, 0); advance();
    end
    drive("sat_end", 0, 0, 0, 0, 0, 0, 0);
    check("sat_count", 32'(cnt), 32'(CNT_MAX));
    advance();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
